// File: rtl/yarp_muldiv_execute.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN iterations, with single-cycle handling of divide special cases.
module yarp_muldiv_execute #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      op_sel_i,
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  logic            kill_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q, op_d;
    logic                neg_q, neg_d;
    logic                special_q, special_d;
    logic [XLEN-1:0]     opnd_q, opnd_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                res_valid_q, res_valid_d;

    // Operand classification at capture time.
    logic            sign_a_s, sign_b_s, is_div_s, div_zero_s, ovf_s;
    logic [XLEN-1:0] mag_a_s, mag_b_s, special_val_s;

    assign is_div_s   = op_sel_i[2];
    assign sign_a_s   = opr_a_i[XLEN-1] & (op_sel_i != 3'b011) & (op_sel_i != 3'b101)
                        & (op_sel_i != 3'b111);
    assign sign_b_s   = opr_b_i[XLEN-1] & ((op_sel_i == 3'b000) | (op_sel_i == 3'b001)
                        | (op_sel_i == 3'b100) | (op_sel_i == 3'b110));
    assign mag_a_s    = sign_a_s ? (~opr_a_i + {{(XLEN-1){1'b0}}, 1'b1}) : opr_a_i;
    assign mag_b_s    = sign_b_s ? (~opr_b_i + {{(XLEN-1){1'b0}}, 1'b1}) : opr_b_i;
    assign div_zero_s = is_div_s & (opr_b_i == {XLEN{1'b0}});
    assign ovf_s      = is_div_s & ~op_sel_i[0] & (opr_a_i == MIN_NEG) & (opr_b_i == {XLEN{1'b1}});
    assign special_val_s = div_zero_s ? (op_sel_i[1] ? opr_a_i : {XLEN{1'b1}})
                                      : (op_sel_i[1] ? {XLEN{1'b0}} : opr_a_i);

    // One iteration step of each algorithm; the remainder shift needs XLEN+1 bits.
    logic [XLEN:0]     mul_sum_s, rem_sh_s, rem_sub_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] prod_neg_s, prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s, rem_fix_s;

    assign mul_sum_s  = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
    assign rem_sh_s   = prod_q[2*XLEN-1:XLEN-1];
    assign div_ge_s   = (rem_sh_s >= {1'b0, opnd_q});
    assign rem_sub_s  = rem_sh_s - {1'b0, opnd_q};
    assign prod_neg_s = ~prod_q + {{(2*XLEN-1){1'b0}}, 1'b1};
    assign prod_fix_s = neg_q ? prod_neg_s : prod_q;
    assign quo_fix_s  = neg_q ? (~prod_q[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : prod_q[XLEN-1:0];
    assign rem_fix_s  = neg_q ? (~prod_q[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                              : prod_q[2*XLEN-1:XLEN];

    // Next-state and datapath update; kill overrides every state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        neg_d       = neg_q;
        special_d   = special_q;
        opnd_d      = opnd_q;
        prod_d      = prod_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (kill_i) begin
            state_d     = S_IDLE;
            cnt_d       = {CNT_W{1'b0}};
            special_d   = 1'b0;
            res_d       = {XLEN{1'b0}};
            res_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        state_d = S_CALC;
                        op_d    = op_sel_i;
                        neg_d   = (is_div_s & op_sel_i[1]) ? sign_a_s : (sign_a_s ^ sign_b_s);
                        if (div_zero_s | ovf_s) begin
                            special_d = 1'b1;
                            cnt_d     = {CNT_W{1'b0}};
                            opnd_d    = {XLEN{1'b0}};
                            prod_d    = {{XLEN{1'b0}}, special_val_s};
                        end else begin
                            special_d = 1'b0;
                            cnt_d     = CNT_W'(XLEN);
                            opnd_d    = is_div_s ? mag_b_s : mag_a_s;
                            prod_d    = {{XLEN{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CALC: begin
                    if (cnt_q != {CNT_W{1'b0}}) begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                        if (op_q[2]) begin
                            prod_d = div_ge_s ? {rem_sub_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b1}
                                              : {rem_sh_s[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
                        end else if (prod_q[0]) begin
                            prod_d = {mul_sum_s, prod_q[XLEN-1:1]};
                        end else begin
                            prod_d = {1'b0, prod_q[2*XLEN-1:1]};
                        end
                    end else begin
                        state_d     = S_DONE;
                        res_valid_d = 1'b1;
                        if (special_q) begin
                            res_d = prod_q[XLEN-1:0];
                        end else begin
                            case (op_q)
                                3'b000:                 res_d = prod_fix_s[XLEN-1:0];
                                3'b001, 3'b010, 3'b011: res_d = prod_fix_s[2*XLEN-1:XLEN];
                                3'b100, 3'b101:         res_d = quo_fix_s;
                                3'b110, 3'b111:         res_d = rem_fix_s;
                                default:                res_d = {XLEN{1'b0}};
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready_i) begin
                        state_d     = S_IDLE;
                        res_d       = {XLEN{1'b0}};
                        res_valid_d = 1'b0;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            op_q        <= 3'b000;
            neg_q       <= 1'b0;
            special_q   <= 1'b0;
            opnd_q      <= {XLEN{1'b0}};
            prod_q      <= {(2*XLEN){1'b0}};
            res_q       <= {XLEN{1'b0}};
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            neg_q       <= neg_d;
            special_q   <= special_d;
            opnd_q      <= opnd_d;
            prod_q      <= prod_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = res_valid_q;
    assign res_o       = res_q;

endmodule
